// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
// The signal names keep the fetch unit's own port names so both ends read the same.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 8
) ();
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [15:0]       imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// hands words to decode, squashing wrong-path fetches on jump/branch redirects.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0]       NOP      = 16'h0020
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              branch_i,
    input  logic [7:0]        displacement_i,
    inst_fetch_unit_if.master imem,
    output logic [15:0]       inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP,
        HOLD
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_idPc;
    logic [ADDR_W-1:0] r_tgt;
    logic [15:0]       r_buf;
    logic [ADDR_W-1:0] r_bufPc;
    logic [15:0]       r_inst;
    logic              r_instValid;
    logic [ADDR_W-1:0] r_instPc;

    logic              w_redirect;
    logic              w_ack;
    logic [ADDR_W-1:0] w_dispExt;
    logic [ADDR_W-1:0] w_target;

    // Branches are relative to the instruction currently sitting in decode.
    assign w_redirect = jump_i | branch_i;
    assign w_dispExt  = ADDR_W'($signed(displacement_i));
    assign w_target   = jump_i ? jump_target_i : (r_idPc + w_dispExt);
    assign w_ack      = imem.imem_ack_i & r_req;

    assign imem.imem_req_o  = r_req;
    assign imem.imem_addr_o = r_pc;
    assign inst_o           = r_inst;
    assign inst_valid_o     = r_instValid;
    assign inst_pc_o        = r_instPc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req       <= 1'b0;
            r_pc        <= RESET_PC;
            r_idPc      <= '0;
            r_tgt       <= '0;
            r_buf       <= NOP;
            r_bufPc     <= '0;
            r_inst      <= NOP;
            r_instValid <= 1'b0;
            r_instPc    <= '0;
        end else begin
            if (!stall_i && !w_redirect) begin
                r_idPc <= r_instPc;
            end
            // A redirect always kills whatever decode would have seen next.
            if (w_redirect) begin
                r_inst      <= NOP;
                r_instValid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_req   <= 1'b1;
                    r_pc    <= w_redirect ? w_target : r_pc;
                    r_state <= FETCH;
                end

                FETCH: begin
                    if (w_redirect) begin
                        if (w_ack) begin
                            r_pc <= w_target;
                        end else begin
                            r_tgt   <= w_target;
                            r_state <= DROP;
                        end
                    end else if (w_ack && !stall_i) begin
                        r_inst      <= imem.imem_rdata_i;
                        r_instValid <= 1'b1;
                        r_instPc    <= r_pc;
                        r_pc        <= r_pc + 1'b1;
                    end else if (w_ack) begin
                        r_buf   <= imem.imem_rdata_i;
                        r_bufPc <= r_pc;
                        r_req   <= 1'b0;
                        r_state <= HOLD;
                    end else if (!stall_i) begin
                        r_inst      <= NOP;
                        r_instValid <= 1'b0;
                    end
                end

                // The outstanding read is wrong-path; wait it out, then go to the target.
                DROP: begin
                    if (!stall_i && !w_redirect) begin
                        r_inst      <= NOP;
                        r_instValid <= 1'b0;
                    end
                    if (w_ack) begin
                        r_pc    <= w_redirect ? w_target : r_tgt;
                        r_state <= FETCH;
                    end else if (w_redirect) begin
                        r_tgt <= w_target;
                    end
                end

                HOLD: begin
                    if (w_redirect) begin
                        r_req   <= 1'b1;
                        r_pc    <= w_target;
                        r_state <= FETCH;
                    end else if (!stall_i) begin
                        r_inst      <= r_buf;
                        r_instValid <= 1'b1;
                        r_instPc    <= r_bufPc;
                        r_req       <= 1'b1;
                        r_pc        <= r_bufPc + 1'b1;
                        r_state     <= FETCH;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a cycle vector table, directed corner
// sequences and a randomised phase, all checked against a transaction scoreboard.
module tb_inst_fetch_unit;

    localparam logic [15:0] NOP = 16'h0020;

    logic       clk_i;
    logic       rst_i;
    logic       stall_i;
    logic       jump_i;
    logic [7:0] jump_target_i;
    logic       branch_i;
    logic [7:0] displacement_i;
    logic [15:0] inst_o;
    logic        inst_valid_o;
    logic [7:0]  inst_pc_o;

    inst_fetch_unit_if #(.ADDR_W(8)) imem ();

    inst_fetch_unit #(
        .ADDR_W  (8),
        .RESET_PC(8'h00),
        .NOP     (NOP)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .branch_i      (branch_i),
        .displacement_i(displacement_i),
        .imem          (imem.master),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .inst_pc_o     (inst_pc_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall;
        logic        jmp;
        logic [7:0]  jt;
        logic        br;
        logic [7:0]  disp;
        logic [15:0] expInst;
        logic        expValid;
        logic [7:0]  expPc;
        logic        expReq;
        logic [7:0]  expAddr;
    } vec_t;

    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  pc;
    } sb_t;

    int checks   = 0;
    int failures = 0;

    // Memory model state and the expected-behaviour model.
    int          memLat  = 0;
    int          memWait = 0;
    sb_t         sbQ[$];
    logic [15:0] expInst;
    logic        expValid;
    logic [7:0]  expPc;
    logic [7:0]  expIdPc;
    logic [7:0]  expNext;
    logic        stale;

    function automatic logic [15:0] memWord(input logic [7:0] a);
        return 16'h1000 + {8'h00, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, answer the memory bus, update the model, compare.
    task automatic applyStimulus(input logic rst, input logic stall, input logic jmp,
                                 input logic [7:0] jt, input logic br, input logic [7:0] disp,
                                 input logic forceAck);
        logic       reqNow;
        logic [7:0] addrNow;
        logic       ackEff;
        logic       useful;
        logic [7:0] tgtM;
        sb_t        e;
        rst_i          = rst;
        stall_i        = stall;
        jump_i         = jmp;
        jump_target_i  = jt;
        branch_i       = br;
        displacement_i = disp;
        reqNow  = imem.imem_req_o;
        addrNow = imem.imem_addr_o;
        ackEff  = 1'b0;
        if (reqNow === 1'b1 && !rst) begin
            if (memWait >= memLat) begin
                ackEff  = 1'b1;
                memWait = 0;
            end else begin
                memWait++;
            end
        end else begin
            memWait = 0;
        end
        imem.imem_ack_i   = ackEff | forceAck;
        imem.imem_rdata_i = ackEff ? memWord(addrNow) : 16'hDEAD;
        useful = ackEff && !stale;
        if (useful) checkOutput("fetchAddr", {24'h0, addrNow}, {24'h0, expNext});

        @(posedge clk_i);
        tgtM = jmp ? jt : (expIdPc + disp);
        if (rst) begin
            expInst  = NOP;
            expValid = 1'b0;
            expPc    = 8'h00;
            expIdPc  = 8'h00;
            expNext  = 8'h00;
            stale    = 1'b0;
            sbQ.delete();
        end else begin
            if (ackEff) stale = 1'b0;
            if (jmp || br) begin
                if (reqNow === 1'b1 && !ackEff) stale = 1'b1;
                sbQ.delete();
                expNext  = tgtM;
                expInst  = NOP;
                expValid = 1'b0;
            end else begin
                if (useful) begin
                    sbQ.push_back('{inst: memWord(expNext), pc: expNext});
                    expNext = expNext + 8'h01;
                end
                if (!stall) begin
                    expIdPc = expPc;
                    if (sbQ.size() > 0) begin
                        e        = sbQ.pop_front();
                        expInst  = e.inst;
                        expPc    = e.pc;
                        expValid = 1'b1;
                    end else begin
                        expInst  = NOP;
                        expValid = 1'b0;
                    end
                end
            end
        end

        @(negedge clk_i);
        checkOutput("sbInst",  {16'h0, inst_o},       {16'h0, expInst});
        checkOutput("sbValid", {31'h0, inst_valid_o}, {31'h0, expValid});
        checkOutput("sbPc",    {24'h0, inst_pc_o},    {24'h0, expPc});
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_inst"},  {16'h0, inst_o},            {16'h0, NOP});
        checkOutput({tag, "_valid"}, {31'h0, inst_valid_o},      32'h0);
        checkOutput({tag, "_pc"},    {24'h0, inst_pc_o},         32'h0);
        checkOutput({tag, "_req"},   {31'h0, imem.imem_req_o},   32'h0);
        checkOutput({tag, "_addr"},  {24'h0, imem.imem_addr_o},  32'h0);
    endtask

    vec_t vecs[17];
    int   validCount;

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_target_i = 8'h00;
        branch_i = 1'b0; displacement_i = 8'h00;
        imem.imem_ack_i = 1'b0; imem.imem_rdata_i = 16'h0000;

        // Zero-wait memory straight out of reset: streaming, stall, jump, branch, jump+branch.
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0020, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1000, 1'b1, 8'h00, 1'b1, 8'h01};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1001, 1'b1, 8'h01, 1'b1, 8'h02};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1002, 1'b1, 8'h02, 1'b1, 8'h03};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1002, 1'b1, 8'h02, 1'b0, 8'h03};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1002, 1'b1, 8'h02, 1'b0, 8'h03};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1002, 1'b1, 8'h02, 1'b0, 8'h03};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1003, 1'b1, 8'h03, 1'b1, 8'h04};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1004, 1'b1, 8'h04, 1'b1, 8'h05};
        vecs[9]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 16'h0020, 1'b0, 8'h04, 1'b1, 8'h10};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1010, 1'b1, 8'h10, 1'b1, 8'h11};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1011, 1'b1, 8'h11, 1'b1, 8'h12};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1011, 1'b1, 8'h11, 1'b0, 8'h12};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFC, 16'h0020, 1'b0, 8'h11, 1'b1, 8'h0C};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h100C, 1'b1, 8'h0C, 1'b1, 8'h0D};
        vecs[15] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h05, 16'h0020, 1'b0, 8'h0C, 1'b1, 8'h40};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1040, 1'b1, 8'h40, 1'b1, 8'h41};

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkResetState("reset");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, vecs[i].stall, vecs[i].jmp, vecs[i].jt, vecs[i].br, vecs[i].disp, 1'b0);
            checkOutput($sformatf("vec%0d_inst", i),  {16'h0, inst_o},           {16'h0, vecs[i].expInst});
            checkOutput($sformatf("vec%0d_valid", i), {31'h0, inst_valid_o},     {31'h0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_pc", i),    {24'h0, inst_pc_o},        {24'h0, vecs[i].expPc});
            checkOutput($sformatf("vec%0d_req", i),   {31'h0, imem.imem_req_o},  {31'h0, vecs[i].expReq});
            checkOutput($sformatf("vec%0d_addr", i),  {24'h0, imem.imem_addr_o}, {24'h0, vecs[i].expAddr});
        end

        // PC wrap from 0xFF to 0x00.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0);
        runIdle(2);
        checkOutput("wrapPc",   {24'h0, inst_pc_o},        32'hFF);
        checkOutput("wrapAddr", {24'h0, imem.imem_addr_o}, 32'h00);
        runIdle(1);
        checkOutput("wrapInst", {16'h0, inst_o}, 32'h1000);

        // Two-wait-state memory: one real instruction every three cycles.
        memLat = 2;
        validCount = 0;
        for (int k = 0; k < 9; k++) begin
            runIdle(1);
            if (inst_valid_o === 1'b1) validCount++;
        end
        checkOutput("slowValidCount", validCount, 3);

        // Redirects while reads are in flight: stale words never reach decode, latest target wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
        runIdle(2);
        checkOutput("dropAddr05", {24'h0, imem.imem_addr_o}, 32'h05);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0);
        runIdle(1);
        checkOutput("dropAddr40", {24'h0, imem.imem_addr_o}, 32'h40);
        checkOutput("dropReq",    {31'h0, imem.imem_req_o},  32'h1);
        checkOutput("dropInst",   {16'h0, inst_o},           {16'h0, NOP});
        checkOutput("dropValid",  {31'h0, inst_valid_o},     32'h0);
        runIdle(3);
        checkOutput("afterDropInst", {16'h0, inst_o},    32'h1040);
        checkOutput("afterDropPc",   {24'h0, inst_pc_o}, 32'h40);

        // Reset in the middle of a read, then a stray ack while no request is up.
        runIdle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkResetState("midReset");
        memLat = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("postResetReq",  {31'h0, imem.imem_req_o},  32'h1);
        checkOutput("postResetAddr", {24'h0, imem.imem_addr_o}, 32'h00);
        runIdle(1);

        // Stray ack while holding a buffered word under stall.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("holdReq", {31'h0, imem.imem_req_o}, 32'h0);
        runIdle(1);
        checkOutput("releaseInst", {16'h0, inst_o},           32'h1001);
        checkOutput("releaseAddr", {24'h0, imem.imem_addr_o}, 32'h02);

        // Randomised traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            if (k % 40 == 0) memLat = $urandom_range(0, 3);
            applyStimulus(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                          8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
                          8'($urandom_range(0, 255)), 1'b0);
        end

        $display("[TB] run complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage feeding the decode-stage instruction register. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents fetched instructions with their PC to decode. Redirects on jump/branch resolved in decode, squashing wrong-path words, including an in-flight memory read. Inserts NOP bubbles when memory is slow and holds output under decode stall.

## Interface
- ADDR_W, 8, PC / instruction-memory word-address width
- RESET_PC, 0, PC fetched first after reset
- NOP, 16'h0020, bubble instruction word
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- stall_i  in  1  decode cannot accept; hold inst_o/inst_valid_o/inst_pc_o
- jump_i  in  1  jump resolved in decode this cycle
- jump_target_i  in  ADDR_W  absolute jump target
- branch_i  in  1  taken branch resolved in decode this cycle
- displacement_i  in  8  signed branch displacement (two's complement)
- imem_req_o  out  1  read request, registered
- imem_addr_o  out  ADDR_W  read word address, registered, stable while imem_req_o=1 until ack
- imem_ack_i  in  1  single-cycle pulse: imem_rdata_i valid, transaction complete
- imem_rdata_i  in  16  read data
- inst_o  out  16  instruction to instruction register
- inst_valid_o  out  1  inst_o is a real instruction (0 = NOP bubble)
- inst_pc_o  out  ADDR_W  PC of inst_o

## Operation
- States: IDLE, FETCH (request outstanding, useful), DROP (request outstanding, stale), HOLD (word buffered, decode stalled).
- Registers: pc (address in flight), id_pc (PC of instruction now in decode), tgt (pending redirect target), buf/buf_pc (held word).
- redirect = jump_i | branch_i. Target = jump_target_i if jump_i (jump wins over branch), else id_pc + sign-extended displacement_i, modulo 2^ADDR_W.
- id_pc <= inst_pc_o at every edge with stall_i=0 and redirect=0.
- Redirect has priority over stall and over everything else: at that edge inst_o<=NOP, inst_valid_o<=0, buf discarded.
- IDLE: imem_req_o<=1, imem_addr_o<=pc; go FETCH.
- FETCH, ack=1, no redirect, stall_i=0: inst_o<=rdata, inst_valid_o<=1, inst_pc_o<=imem_addr_o; address<=+1 (wraps), imem_req_o stays 1.
- FETCH, ack=1, stall_i=1: buf<=rdata, buf_pc<=addr; imem_req_o<=0; outputs hold; go HOLD.
- FETCH, ack=1, redirect: data discarded; imem_addr_o<=target; imem_req_o stays 1; stay FETCH.
- FETCH, ack=0, redirect: tgt<=target; go DROP (imem_req_o, address unchanged).
- FETCH, ack=0, no redirect: stall_i=0 -> inst_o<=NOP, inst_valid_o<=0; stall_i=1 -> outputs hold.
- DROP: outputs NOP/invalid (unless stalled then hold). Further redirect overwrites tgt (latest wins). On ack: data discarded, imem_addr_o<=tgt (or new target if redirect same cycle), go FETCH.
- HOLD: stall_i=0 -> inst_o<=buf, inst_valid_o<=1, inst_pc_o<=buf_pc, imem_req_o<=1, imem_addr_o<=buf_pc+1, go FETCH. Redirect -> buf dropped, imem_req_o<=1, imem_addr_o<=target, go FETCH.
- imem_ack_i ignored whenever imem_req_o=0.

## Timing
- Reset values: state IDLE, imem_req_o=0, imem_addr_o=RESET_PC, pc=RESET_PC, id_pc=0, inst_o=NOP, inst_valid_o=0, inst_pc_o=0.
- First request: imem_req_o=1, address RESET_PC, on 1st edge after rst_i falls.
- Ack may come in any cycle imem_req_o=1 (zero-wait allowed); zero-wait memory gives 1 instruction/cycle.
- Ack in cycle n -> inst_o valid from edge ending n.
- Redirect in cycle n with ack in n (or in HOLD): target address on imem_addr_o from edge ending n; zero-wait -> target instruction valid after n+1.
- Reset mid-transaction: abandons in-flight read; memory must tolerate req dropping without ack.

## Test plan
- Reset, zero-wait memory returning mem[a]=16'h1000+a -> inst_o 16'h1000,1001,1002 on consecutive cycles, inst_pc_o 0,1,2, no bubbles.
- Memory ack 2 cycles after each request -> pattern valid, NOP, NOP-free alternation: exactly one inst_valid_o=1 per 3 cycles, inst_o=NOP/valid 0 between.
- Stall 3 cycles while ack arrives -> inst_o holds previous word, imem_req_o=0; on release buffered word appears next edge, fetch resumes at buf_pc+1.
- Branch with id_pc=8'h10, displacement_i=8'hFC, no request pending -> imem_addr_o=8'h0C next edge, inst_o=NOP, inst_valid_o=0 that edge.
- Jump to 8'h40 while 3-cycle read of 8'h05 pending -> DROP; returned word never appears on inst_o; next request address 8'h40. Simultaneous jump_i and branch_i -> jump_target_i used.
- PC 8'hFF fetched -> next address 8'h00; rst_i mid-read -> outputs return to reset values next edge, stale ack ignored.
